// File: rtl/lb_pkg.sv
// lb_pkg: shared state type and width helper for the line buffer window
package lb_pkg;
  typedef enum logic {PRIME, STREAM} lb_state_t;
  function automatic int lb_clog2(input int n);
    int w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/line_buffer_ram.sv
// line_buffer_ram: single-port line memory, combinational read of old contents
module line_buffer_ram
  import lb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 640
) (
  input  logic                        clk,
  input  logic [lb_clog2(DEPTH)-1:0]  addr,
  input  logic                        we,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  assign rdata = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/line_buffer_window.sv
// line_buffer_window: vertical pixel column from NUM_LINES stored lines; LB_POS_OUT_EN adds col_o/row_o
module line_buffer_window
  import lb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LINE_WIDTH = 640,
  parameter int NUM_LINES  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic                             sof_i,
  input  logic [DATA_W-1:0]                data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [(NUM_LINES+1)*DATA_W-1:0]  taps_o,
  output logic                             primed_o
`ifdef LB_POS_OUT_EN
  ,
  output logic [lb_clog2(LINE_WIDTH)-1:0]  col_o,
  output logic [15:0]                      row_o
`endif
);
  localparam int CW = lb_clog2(LINE_WIDTH);
  localparam int RW = lb_clog2(NUM_LINES + 1);
  lb_state_t state, state_nxt;
  logic [CW-1:0] col, col_cur, col_nxt;
  logic [RW-1:0] row, row_nxt;
  logic accept, wrap, emit;
  logic [DATA_W-1:0] rd [NUM_LINES];
  logic [DATA_W-1:0] wd [NUM_LINES];
  logic [(NUM_LINES+1)*DATA_W-1:0] taps_nxt;

  assign in_ready_o = !out_valid_o | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;
  assign col_cur    = sof_i ? '0 : col;
  assign wrap       = col_cur == CW'(LINE_WIDTH - 1);
  assign emit       = accept & (state == STREAM) & !sof_i;
  assign primed_o   = state == STREAM;

  // each line feeds the next, so an accept shifts the whole column down one line
  for (genvar j = 0; j < NUM_LINES; j++) begin : g_line
    if (j == 0) begin : g_head
      assign wd[j] = data_i;
    end else begin : g_tail
      assign wd[j] = rd[j-1];
    end
    line_buffer_ram #(.DATA_W(DATA_W), .DEPTH(LINE_WIDTH)) u_ram (
      .clk   (clk),
      .addr  (col_cur),
      .we    (accept),
      .wdata (wd[j]),
      .rdata (rd[j])
    );
  end

  always_comb begin
    taps_nxt = '0;
    taps_nxt[DATA_W-1:0] = data_i;
    for (int k = 0; k < NUM_LINES; k++) taps_nxt[(k+1)*DATA_W +: DATA_W] = rd[k];
  end

  always_comb begin
    col_nxt   = col;
    row_nxt   = row;
    state_nxt = state;
    if (accept) begin
      col_nxt   = wrap ? '0 : col_cur + 1'b1;
      row_nxt   = sof_i ? '0 : (wrap && row != RW'(NUM_LINES)) ? row + 1'b1 : row;
      state_nxt = sof_i ? PRIME :
                  (state == PRIME && wrap && row == RW'(NUM_LINES - 1)) ? STREAM : state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PRIME;
      col         <= '0;
      row         <= '0;
      out_valid_o <= 1'b0;
      taps_o      <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      if (accept) out_valid_o <= emit;
      else if (out_ready_i) out_valid_o <= 1'b0;
      if (emit) taps_o <= taps_nxt;
    end
  end

`ifdef LB_POS_OUT_EN
  logic [15:0] frow;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frow  <= '0;
      col_o <= '0;
      row_o <= '0;
    end else begin
      if (accept) frow <= sof_i ? 16'd0 : frow + 16'(wrap);
      if (emit) begin
        col_o <= col;
        row_o <= frow;
      end
    end
  end
`endif
endmodule

// File: tb/tb_line_buffer_window.sv
// tb_line_buffer_window: randomized scoreboard bench against a frame-array reference model
module tb_line_buffer_window;
  localparam int DW = 8, LW = 5, NL = 2, TW = (NL + 1) * DW;
  logic clk = 0, rst_n = 1, in_valid_i = 0, sof_i = 0, out_ready_i = 1;
  logic [DW-1:0] data_i = '0;
  logic in_ready_o, out_valid_o, primed_o;
  logic [TW-1:0] taps_o;
`ifdef LB_POS_OUT_EN
  logic [2:0] col_o;
  logic [15:0] row_o;
`endif
  typedef struct {
    logic [TW-1:0] taps;
    int col;
    int row;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  logic [DW-1:0] frame[$];
  int vecs = 0, errs = 0;
  int rdy_pct = 100, gap_pct = 0;

  always #5 clk = ~clk;

  line_buffer_window #(.DATA_W(DW), .LINE_WIDTH(LW), .NUM_LINES(NL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .sof_i       (sof_i),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .taps_o      (taps_o),
    .primed_o    (primed_o)
`ifdef LB_POS_OUT_EN
    ,
    .col_o       (col_o),
    .row_o       (row_o)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: keep the whole current frame; tap k is the pixel k*LW earlier in the frame
  task automatic model_accept(input logic [DW-1:0] d, input logic s);
    exp_t e;
    int i;
    if (s) frame.delete();
    frame.push_back(d);
    i = frame.size() - 1;
    if (i >= NL * LW) begin
      e.taps = '0;
      e.taps[DW-1:0] = d;
      for (int k = 1; k <= NL; k++) e.taps[k*DW +: DW] = frame[i - k*LW];
      e.col = i % LW;
      e.row = (i / LW) % 65536;
      sb.push_back(e);
    end
  endtask

  task automatic send_px(input logic [DW-1:0] d, input logic s);
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      out_ready_i = $urandom_range(99) < rdy_pct;
      in_valid_i  = $urandom_range(99) >= gap_pct;
      data_i = d;
      sof_i  = s;
      #1;
      if (in_valid_i && in_ready_o) begin
        model_accept(d, s);
        done = 1;
        @(posedge clk);
        #1;
        check("primed", primed_o, 64'(frame.size() >= NL * LW));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid_i  = 0;
      out_ready_i = $urandom_range(99) < rdy_pct;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_output: got taps %0h, expected no output", taps_o);
        end else begin
          me = sb.pop_front();
          check("taps", taps_o, me.taps);
`ifdef LB_POS_OUT_EN
          check("col_o", col_o, me.col);
          check("row_o", row_o, me.row);
`endif
        end
      end
    end
  end

  initial begin
    #1 rst_n = 0;
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_taps", taps_o, 0);
    check("rst_primed", primed_o, 0);
    check("rst_ready", in_ready_o, 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int p = 1; p <= 15; p++) send_px(p, p == 1);
    idle(3);
    for (int p = 1; p <= 11; p++) send_px(p, p == 1);
    repeat (4) begin
      @(negedge clk);
      out_ready_i = 0;
      in_valid_i  = 1;
      data_i      = 12;
      sof_i       = 0;
      #1;
      check("hold_ready", in_ready_o, 0);
      check("hold_valid", out_valid_o, 1);
      check("hold_taps", taps_o, 24'h01060b);
    end
    for (int p = 12; p <= 15; p++) send_px(p, 0);
    idle(3);
    gap_pct = 30;
    for (int p = 1; p <= 15; p++) send_px(p, p == 1);
    rdy_pct = 70;
    for (int p = 0; p < 80; p++) send_px($urandom_range(255), $urandom_range(99) < 5);
    rdy_pct = 100;
    gap_pct = 0;
    idle(3);
    for (int p = 1; p <= 12; p++) send_px(p, p == 1);
    send_px(13, 1);
    for (int p = 14; p <= 30; p++) send_px(p, 0);
    idle(3);
    for (int p = 1; p <= 7; p++) send_px(p, p == 1);
    @(negedge clk);
    in_valid_i  = 1;
    data_i      = 8;
    sof_i       = 0;
    out_ready_i = 1;
    #2 rst_n = 0;
    #1;
    check("arst_valid", out_valid_o, 0);
    check("arst_taps", taps_o, 0);
    check("arst_primed", primed_o, 0);
    check("arst_ready", in_ready_o, 1);
    sb.delete();
    frame.delete();
    @(negedge clk);
    in_valid_i = 0;
    rst_n = 1;
    for (int p = 1; p <= 15; p++) send_px(p, p == 1);
    in_valid_i  = 0;
    out_ready_i = 1;
    for (int c = 0; c < 50 && sb.size() != 0; c++) @(negedge clk);
    check("drain_pending", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
